// File: rtl/xor_unit_if.sv
// Handshake/data bundle for xor_unit: operands and in-side handshake from upstream,
// combinational and registered results plus out-side handshake from the unit.
interface xor_unit_if #(
    parameter int WIDTH = 1
);
    localparam int CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic             parity_q;
    logic [CNT_W-1:0] diff_count_q;

    modport master (
        output in1, in2, in_valid, out_ready,
        input  out, in_ready, out_valid, out_q, parity_q, diff_count_q
    );

    modport slave (
        input  in1, in2, in_valid, out_ready,
        output out, in_ready, out_valid, out_q, parity_q, diff_count_q
    );
endinterface

// File: rtl/xor_unit.sv
// Bitwise XOR with a live combinational output and a single-entry registered stage
// carrying the XOR result, its parity and the Hamming distance of the operands.
module xor_unit #(
    parameter int WIDTH = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    xor_unit_if.slave bus
);
    localparam int CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             valid_r;
    logic [WIDTH-1:0] q_r;
    logic             par_r;
    logic [CNT_W-1:0] cnt_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i] = bus.in1[i] ^ bus.in2[i];
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(diff[i]);
        end
    end

    // Pass-through ready: a consumed result frees the slot in the same cycle.
    assign bus.in_ready = !valid_r || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            q_r     <= '0;
            par_r   <= 1'b0;
            cnt_r   <= '0;
        end else if (accept) begin
            valid_r <= 1'b1;
            q_r     <= diff;
            par_r   <= ^diff;
            cnt_r   <= cnt;
        end else if (bus.out_ready) begin
            // Data fields are left stale on release; only the valid flag drops.
            valid_r <= 1'b0;
        end
    end

    assign bus.out          = diff;
    assign bus.out_valid    = valid_r;
    assign bus.out_q        = q_r;
    assign bus.parity_q     = par_r;
    assign bus.diff_count_q = cnt_r;
endmodule

// File: tb/tb_xor_unit.sv
// Directed bench for xor_unit at WIDTH=1 and WIDTH=8 with a per-instance scoreboard.
module tb_xor_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    xor_unit_if #(.WIDTH(1)) b1 ();
    xor_unit_if #(.WIDTH(8)) b8 ();

    xor_unit #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    xor_unit #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    typedef struct packed {
        logic [7:0] q;
        logic       p;
        logic [3:0] c;
    } exp_t;

    exp_t sb1[$];
    exp_t sb8[$];
    logic m1_valid = 1'b0;
    logic m8_valid = 1'b0;

    function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.q = a ^ b;
        e.c = 4'd0;
        for (int i = 0; i < 8; i++) if (e.q[i]) e.c = e.c + 4'd1;
        e.p = (e.c % 2 == 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc8(input logic [7:0] a, input logic [7:0] b, input logic v, input logic r);
        logic acc, rel;
        @(negedge clk);
        b8.in1 = a; b8.in2 = b; b8.in_valid = v; b8.out_ready = r;
        #1;
        chk("w8_out", 64'(b8.out), 64'(a ^ b));
        chk("w8_in_ready", 64'(b8.in_ready), 64'(!m8_valid || r));
        acc = v && (!m8_valid || r);
        rel = m8_valid && r;
        @(posedge clk); #1;
        if (rel) void'(sb8.pop_front());
        if (acc) sb8.push_back(ref_model(a, b));
        m8_valid = acc | (m8_valid & ~rel);
        chk("w8_out_valid", 64'(b8.out_valid), 64'(m8_valid));
        if (sb8.size() > 0) begin
            chk("w8_out_q", 64'(b8.out_q), 64'(sb8[0].q));
            chk("w8_parity_q", 64'(b8.parity_q), 64'(sb8[0].p));
            chk("w8_diff_count_q", 64'(b8.diff_count_q), 64'(sb8[0].c));
        end
    endtask

    task automatic cyc1(input logic a, input logic b, input logic v, input logic r);
        logic acc, rel;
        exp_t e;
        @(negedge clk);
        b1.in1 = a; b1.in2 = b; b1.in_valid = v; b1.out_ready = r;
        #1;
        chk("w1_out", 64'(b1.out), 64'(a ^ b));
        acc = v && (!m1_valid || r);
        rel = m1_valid && r;
        @(posedge clk); #1;
        if (rel) void'(sb1.pop_front());
        if (acc) begin
            e = ref_model({7'd0, a}, {7'd0, b});
            sb1.push_back(e);
        end
        m1_valid = acc | (m1_valid & ~rel);
        chk("w1_out_valid", 64'(b1.out_valid), 64'(m1_valid));
        if (sb1.size() > 0) begin
            chk("w1_out_q", 64'(b1.out_q), 64'(sb1[0].q[0]));
            chk("w1_parity_q", 64'(b1.parity_q), 64'(sb1[0].p));
            chk("w1_diff_count_q", 64'(b1.diff_count_q), 64'(sb1[0].c[0]));
        end
    endtask

    initial begin
        logic [1:0] v1;
        logic [7:0] ra, rb;
        b1.in1 = 1'b0; b1.in2 = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
        b8.in1 = 8'h00; b8.in2 = 8'h00; b8.in_valid = 1'b0; b8.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(b8.out_valid), 64'(0));
        chk("rst_out_q", 64'(b8.out_q), 64'(0));
        chk("rst_parity_q", 64'(b8.parity_q), 64'(0));
        chk("rst_diff_count_q", 64'(b8.diff_count_q), 64'(0));
        chk("rst_w1_out_valid", 64'(b1.out_valid), 64'(0));

        // Combinational truth table while held in reset.
        for (int i = 0; i < 4; i++) begin
            v1 = 2'(i);
            b1.in1 = v1[1]; b1.in2 = v1[0];
            #10;
            chk("w1_comb_in_reset", 64'(b1.out), 64'(v1[1] != v1[0]));
        end

        @(negedge clk) rst_n = 1'b1;
        #1 chk("w8_in_ready_after_rst", 64'(b8.in_ready), 64'(1));

        // WIDTH=1 back-to-back stream, then drain.
        cyc1(1'b0, 1'b0, 1'b1, 1'b1);
        cyc1(1'b0, 1'b1, 1'b1, 1'b1);
        cyc1(1'b1, 1'b0, 1'b1, 1'b1);
        cyc1(1'b1, 1'b1, 1'b1, 1'b1);
        cyc1(1'b0, 1'b0, 1'b0, 1'b1);

        // WIDTH=8 full and single-bit differences.
        cyc8(8'hF0, 8'h0F, 1'b1, 1'b1);
        cyc8(8'hA5, 8'hA4, 1'b1, 1'b1);
        cyc8(8'h00, 8'h00, 1'b0, 1'b1);

        // Backpressure: result held while operands wander, then accept on release.
        cyc8(8'h3C, 8'h00, 1'b1, 1'b0);
        cyc8(8'h11, 8'h22, 1'b1, 1'b0);
        cyc8(8'hFF, 8'h01, 1'b1, 1'b0);
        cyc8(8'h80, 8'h7F, 1'b1, 1'b0);
        cyc8(8'h5A, 8'h5A, 1'b1, 1'b1);
        cyc8(8'h00, 8'h00, 1'b0, 1'b1);

        // Reset pulse between clock edges with a stalled result.
        cyc8(8'h77, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        b8.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(b8.out_valid), 64'(0));
        chk("midrst_out_q", 64'(b8.out_q), 64'(0));
        chk("midrst_parity_q", 64'(b8.parity_q), 64'(0));
        chk("midrst_diff_count_q", 64'(b8.diff_count_q), 64'(0));
        sb8.delete(); m8_valid = 1'b0;
        sb1.delete(); m1_valid = 1'b0;
        #1 rst_n = 1'b1;
        #1 chk("midrst_in_ready", 64'(b8.in_ready), 64'(1));

        // Random operands with random downstream stalls.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            cyc8(ra, rb, 1'($urandom), 1'($urandom));
        end
        cyc8(8'h00, 8'h00, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
